// File: rtl/en_delay_pkg.sv
// Shared types and helpers for the parametrised enable delay pipe.
// Holds the drain-tracking FSM encoding and the tap-select width function.
package en_delay_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int sel_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/en_delay_stage.sv
// One delay stage: a valid bit plus payload, with flush (priority) and stall.
module en_delay_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              valid_q,
    output logic [DATA_W-1:0] data_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (!stall) begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/en_delay_pipe.sv
// DEPTH-stage enable/payload delay line with runtime tap select and drain FSM.
// Optional occupancy counter is built only when EN_DELAY_OCC_EN is defined.
module en_delay_pipe
    import en_delay_pkg::*;
#(
    parameter  int DEPTH  = 15,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = sel_w(DEPTH),
    localparam int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              stall,
    input  logic              flush,
    input  logic [SEL_W-1:0]  tap_sel,
    output logic [DEPTH-1:0]  en_taps,
    output logic              en_out,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              drained,
    output logic [ST_W-1:0]   state,
    output logic [OCC_W-1:0]  occ
);

    // en_in qualifies data_in on every advance cycle; there is no backpressure,
    // so anything presented during stall or flush is simply dropped.
    logic [DEPTH-1:0]  valid;
    logic [DATA_W-1:0] data [DEPTH];
    logic [DATA_W-1:0] stage0_d;
    logic [DEPTH-1:0]  shifted;
    state_t            st_q;

    assign stage0_d = en_in ? data_in : '0;
    assign shifted  = {valid[DEPTH-2:0], en_in};

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            en_delay_stage #(.DATA_W(DATA_W)) u_stage (
                .clk(clk), .rst(rst), .stall(stall), .flush(flush),
                .valid_d(en_in), .data_d(stage0_d),
                .valid_q(valid[k]), .data_q(data[k])
            );
        end else begin : g_rest
            en_delay_stage #(.DATA_W(DATA_W)) u_stage (
                .clk(clk), .rst(rst), .stall(stall), .flush(flush),
                .valid_d(valid[k-1]), .data_d(data[k-1]),
                .valid_q(valid[k]), .data_q(data[k])
            );
        end
    end

    assign en_taps = valid;
    assign busy    = |valid;
    assign state   = st_q;

    always_comb begin
        en_out   = 1'b0;
        data_out = '0;
        if (int'(tap_sel) < DEPTH) begin
            en_out   = valid[tap_sel];
            data_out = data[tap_sel];
        end
    end

    // Emptiness is judged on the post-shift vector so drained lines up with
    // the edge that actually pushed the last valid out of stage DEPTH-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q    <= IDLE;
            drained <= 1'b0;
        end else begin
            drained <= 1'b0;
            if (flush) begin
                st_q <= IDLE;
            end else if (!stall) begin
                case (st_q)
                    IDLE: begin
                        if (en_in) st_q <= FILL;
                    end
                    FILL: begin
                        if (!en_in) begin
                            if (|shifted) begin
                                st_q <= DRAIN;
                            end else begin
                                st_q    <= IDLE;
                                drained <= 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (en_in) begin
                            st_q <= FILL;
                        end else if (~|shifted) begin
                            st_q    <= IDLE;
                            drained <= 1'b1;
                        end
                    end
                    default: st_q <= IDLE;
                endcase
            end
        end
    end

`ifdef EN_DELAY_OCC_EN
    logic [OCC_W-1:0] occ_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (!stall) begin
            occ_q <= occ_q + OCC_W'(en_in) - OCC_W'(valid[DEPTH-1]);
        end
    end

    assign occ = occ_q;
`else
    assign occ = '0;
`endif

endmodule

// File: doc/en_delay_pipe.md
Name: en_delay_pipe

Overview:
- Parametrised successor to the fixed 15-stage enable delay chain.
- Carries a valid/enable bit plus a DATA_W payload through DEPTH register stages, with stall and flush controls.
- A runtime-selectable output tap chooses the delay; a drain-tracking FSM reports when the pipe has emptied.
- Sits between the control sequencer and the datapath units that need enables aligned to their pipeline latency.

Parameters:
- DEPTH, 15, number of delay stages; legal range 2..64.
- DATA_W, 8, payload width carried alongside each enable.
- SEL_W, $clog2(DEPTH), tap-select width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en_in  in  1  enable/valid entering stage 0.
- data_in  in  DATA_W  payload captured with en_in.
- stall  in  1  freezes all stages when high.
- flush  in  1  clears all stages; priority over stall.
- tap_sel  in  SEL_W  stage driven onto en_out/data_out.
- en_taps  out  DEPTH  valid bit of every stage; bit k = stage k.
- en_out  out  1  valid of stage tap_sel.
- data_out  out  DATA_W  payload of stage tap_sel.
- busy  out  1  OR of all stage valids.
- drained  out  1  one-cycle pulse when the pipe empties by shifting.
- state  out  2  FSM state: IDLE=0, FILL=1, DRAIN=2.
- occ  out  $clog2(DEPTH+1)  occupancy; see Optional Feature.

Behaviour:
- Reset (rst low, asynchronous): all valids 0, all payloads 0, state IDLE, drained 0, occ 0.
- Advance cycle (stall=0, flush=0):
  - valid[0] <= en_in; data[0] <= en_in ? data_in : 0.
  - valid[k] <= valid[k-1] and data[k] <= data[k-1], for k = 1..DEPTH-1.
  - Stage DEPTH-1 contents are discarded.
- Latency: en_in high at edge t appears on en_taps[k] after edge t+1+k.
- Stall (stall=1, flush=0): every stage holds; en_in/data_in are dropped, not queued.
- Flush (flush=1): all valids and payloads go to 0 on the next edge, regardless of stall or en_in. The en_in of that cycle is discarded.
- Tap output is combinational from registers:
  - en_out = valid[tap_sel], data_out = data[tap_sel].
  - tap_sel >= DEPTH gives en_out=0, data_out=0.
  - tap_sel may change on any cycle.
- busy = |valid, combinational from registers.
- FSM (updates only on advance cycles, except flush):
  - IDLE -> FILL when en_in=1.
  - FILL -> DRAIN when en_in=0 and at least one valid remains after the shift.
  - FILL -> IDLE when en_in=0 and the pipe becomes empty (only possible if only stage DEPTH-1 held a valid); drained pulses.
  - DRAIN -> FILL when en_in=1.
  - DRAIN -> IDLE when the post-shift valid vector is all zero; drained=1 for exactly that cycle.
  - Flush from any state -> IDLE with no drained pulse.
  - Stall holds state; drained stays 0 during stall.
- drained is registered and asserted in the cycle after the emptying edge.
- All outputs are glitch-free register or mux-of-register paths; there is no combinational path from en_in to any output.

Optional Feature:
- Macro EN_DELAY_OCC_EN.
- Defined: occ is a registered count of set valid bits. It is updated incrementally on advance: +en_in, -valid[DEPTH-1]. Flush or reset sets it to 0; stall holds it. It must always equal popcount(en_taps).
- Undefined: occ is tied to 0 and no counter logic is generated. The port list is unchanged.

Decomposition:
- Package en_delay_pkg holds:
  - state enum (IDLE, FILL, DRAIN) with 2-bit encoding;
  - function sel_w(depth) returning the tap-select width;
  - localparam ST_W=2.
- Sub-module en_delay_stage: one valid+payload register with stall/flush/async reset, instantiated DEPTH times via generate.

Test Plan:
- Single pulse, DEPTH=15, tap_sel=14: en_in=1 with data 0xA5 at cycle 0 -> en_out=1, data_out=0xA5 at cycle 15 only; drained pulse at cycle 16; state back to IDLE.
- Tap sweep: pulse data 0x3C at cycle 0, tap_sel=3 -> en_out high at cycle 4; tap_sel=15 -> en_out never high, data_out=0.
- Stall: pulse at cycle 0, stall high cycles 5-7 -> en_taps[14] high at cycle 18; en_in=1 during cycles 5-7 produces no valid.
- Flush mid-flight: 4 consecutive pulses, flush at cycle 6 -> en_taps=0 at cycle 7, busy=0, state IDLE, no drained pulse; flush+stall together still clears.
- Reset mid-operation: rst low while 5 stages are valid -> all outputs 0 immediately (asynchronous); after release, first en_in restarts from IDLE.
- With EN_DELAY_OCC_EN, random en_in/stall/flush for 2000 cycles -> occ == popcount(en_taps) every cycle; without the macro, occ==0 throughout.
